vga_pattern_gen: RTL

Downstream consumer of the VGA sync generator: samples its `h_sync`/`v_sync` outputs, locks onto the 800×525 timing, and reconstructs pixel/line position. Produces data-enable, x/y coordinates and a 12-bit RGB colour-bar test pattern aligned to the sync stream. Drives the DAC/pin stage and serves as bring-up stimulus for the display path.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_bar_pattern.sv | 109 ++++++++++
 rtl/vga_pattern_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, lock-FSM state type and colour-bar palette for the
// VGA pattern generator.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int BAR_COUNT = 8;

  typedef enum logic [1:0] {
    SEARCH,
    HLOCK,
    LOCKED
  } vga_lock_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb444_t BAR_COLOURS [BAR_COUNT] = '{
    rgb444_t'(12'hFFF), rgb444_t'(12'hFF0), rgb444_t'(12'h0FF), rgb444_t'(12'h0F0),
    rgb444_t'(12'hF0F), rgb444_t'(12'hF00), rgb444_t'(12'h00F), rgb444_t'(12'h000)
  };

endpackage

// File: rtl/vga_bar_pattern.sv
// Eight-bar colour pattern driven by a running bar counter (no divider).
// VGA_PATTERN_SCROLL_EN adds a per-frame phase offset so the bars scroll left.
module vga_bar_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE
) (
  input  logic        ck,
  input  logic        reset,
`ifdef VGA_PATTERN_SCROLL_EN
  input  logic        locked,
`endif
  input  logic        de,
  input  logic [9:0]  x,
  input  logic        frame_start,
  output logic [11:0] rgb
);

  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / BAR_COUNT - 1);

  logic [9:0] pix_q;
  logic [2:0] bar_q;
  logic [9:0] start_pix;
  logic [2:0] start_bar;
  logic [9:0] cur_pix;
  logic [2:0] cur_bar;

`ifdef VGA_PATTERN_SCROLL_EN
  localparam logic [9:0] OFF_LAST = 10'(H_ACTIVE - 1);

  // The offset is held both as a pixel count and as (bar, pixel-in-bar) so the
  // line-start phase is available without dividing.
  logic [9:0] offset_q;
  logic [9:0] off_pix_q;
  logic [2:0] off_bar_q;
  logic [9:0] eff_off;
  logic [9:0] eff_pix;
  logic [2:0] eff_bar;

  always_comb begin
    eff_off = offset_q;
    eff_pix = off_pix_q;
    eff_bar = off_bar_q;
    if (frame_start) begin
      if (offset_q == OFF_LAST) begin
        eff_off = '0;
        eff_pix = '0;
        eff_bar = '0;
      end else begin
        eff_off = offset_q + 10'd1;
        if (off_pix_q == BAR_LAST) begin
          eff_pix = '0;
          eff_bar = off_bar_q + 3'd1;
        end else begin
          eff_pix = off_pix_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (reset || !locked) begin
      offset_q  <= '0;
      off_pix_q <= '0;
      off_bar_q <= '0;
    end else if (frame_start) begin
      offset_q  <= eff_off;
      off_pix_q <= eff_pix;
      off_bar_q <= eff_bar;
    end
  end

  assign start_pix = eff_pix;
  assign start_bar = eff_bar;
`else
  assign start_pix = '0;
  assign start_bar = '0;
`endif

  always_comb begin
    cur_pix = pix_q;
    cur_bar = bar_q;
    if (x == '0) begin
      cur_pix = start_pix;
      cur_bar = start_bar;
    end
  end

  // BAR_COLOURS is a constant table, so only the counters and rgb need reset.
  always_ff @(posedge ck) begin
    if (reset) begin
      pix_q <= '0;
      bar_q <= '0;
      rgb   <= '0;
    end else begin
      rgb <= de ? BAR_COLOURS[cur_bar] : '0;
      if (de) begin
        if (cur_pix == BAR_LAST) begin
          pix_q <= '0;
          bar_q <= cur_bar + 3'd1;
        end else begin
          pix_q <= cur_pix + 10'd1;
          bar_q <= cur_bar;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Locks onto an external h_sync/v_sync stream and emits de, x/y and a colour-bar
// pattern aligned to it. Optional scrolling bars: VGA_PATTERN_SCROLL_EN.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter logic H_POL      = 1'b1,
  parameter logic V_POL      = 1'b0,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_TOTAL    = VGA_H_TOTAL,
  parameter int   V_BP       = VGA_V_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_TOTAL    = VGA_V_TOTAL,
  parameter int   LOCK_LINES = 4
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic        locked
);

  localparam int                LCNT_W   = $clog2(LOCK_LINES + 1);
  localparam logic [LCNT_W-1:0] LOCK_CNT = LCNT_W'(LOCK_LINES);
  localparam logic [LCNT_W-1:0] CNT_ONE  = LCNT_W'(1);
  localparam logic [9:0]        CNT_MAX  = '1;
  localparam logic [9:0]        H_START  = 10'(H_BP);
  localparam logic [9:0]        H_END    = 10'(H_BP + H_ACTIVE);
  localparam logic [9:0]        V_START  = 10'(V_BP);
  localparam logic [9:0]        V_END    = 10'(V_BP + V_ACTIVE);

  logic            hs_q, hs_d, vs_q, vs_d;
  logic            h_trail, v_trail;
  logic            line_ok, frame_ok;
  logic [9:0]      hcnt, vcnt;
  vga_lock_state_t state, state_next;
  logic [LCNT_W-1:0] good_cnt, good_cnt_next;
  logic            lock_live;
  logic            de_next, fs_next;
  logic [9:0]      x_next, y_next;

  // NOTE: sequential state is written with <= so every flop sees pre-edge values
  // regardless of block order; the reset is synchronous and sampled on ck.
  always_ff @(posedge ck) begin
    if (reset) begin
      hs_q <= ~H_POL;
      hs_d <= ~H_POL;
      vs_q <= ~V_POL;
      vs_d <= ~V_POL;
    end else begin
      hs_q <= h_sync;
      hs_d <= hs_q;
      vs_q <= v_sync;
      vs_d <= vs_q;
    end
  end

  assign h_trail  = (hs_d == H_POL) && (hs_q != H_POL);
  assign v_trail  = (vs_d == V_POL) && (vs_q != V_POL);
  assign line_ok  = (int'(hcnt) + 1) == H_TOTAL;
  assign frame_ok = (int'(vcnt) + 1) == V_TOTAL;

  // A coincident v edge clears vcnt instead of advancing it.
  always_ff @(posedge ck) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (h_trail)              hcnt <= '0;
      else if (hcnt != CNT_MAX) hcnt <= hcnt + 10'd1;
      if (v_trail)      vcnt <= '0;
      else if (h_trail) vcnt <= vcnt + 10'd1;
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    unique case (state)
      SEARCH: begin
        if (h_trail) begin
          state_next    = HLOCK;
          good_cnt_next = '0;
        end
      end
      HLOCK: begin
        if (h_trail) begin
          if (!line_ok)                 good_cnt_next = '0;
          else if (good_cnt < LOCK_CNT) good_cnt_next = good_cnt + CNT_ONE;
        end
        if (v_trail && (good_cnt >= LOCK_CNT) && !(h_trail && !line_ok))
          state_next = LOCKED;
      end
      LOCKED: begin
        if ((h_trail && !line_ok) || (v_trail && !frame_ok)) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  assign lock_live = (state == LOCKED);

  always_comb begin
    de_next = lock_live && (hcnt >= H_START) && (hcnt < H_END)
                        && (vcnt >= V_START) && (vcnt < V_END);
    x_next  = de_next ? hcnt - H_START : '0;
    y_next  = de_next ? vcnt - V_START : '0;
    fs_next = de_next && (x_next == '0) && (y_next == '0);
  end

  // Outputs lag the counters by one edge; locked shares that pipeline stage.
  always_ff @(posedge ck) begin
    if (reset) begin
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      de          <= de_next;
      x           <= x_next;
      y           <= y_next;
      frame_start <= fs_next;
      locked      <= lock_live;
    end
  end

  vga_bar_pattern #(
    .H_ACTIVE(H_ACTIVE)
  ) u_bars (
    .ck         (ck),
    .reset      (reset),
`ifdef VGA_PATTERN_SCROLL_EN
    .locked     (lock_live),
`endif
    .de         (de_next),
    .x          (x_next),
    .frame_start(fs_next),
    .rgb        (rgb)
  );

endmodule
